// File: rtl/lim_integrator_if.sv
// rtl/lim_integrator_if.sv - sample/result handshake bundle for lim_integrator
interface lim_integrator_if #(
  parameter int IW  = 14,
  parameter int KW  = 14,
  parameter int RES = 14
) ();
  logic signed [IW-1:0]  err;
  logic                  err_valid;
  logic signed [KW-1:0]  ki;
  logic signed [RES-1:0] out;
  logic                  out_valid;

  modport master (output err, err_valid, ki, input out, out_valid);
  modport slave  (input err, err_valid, ki, output out, out_valid);
endinterface

// File: rtl/lim_integrator.sv
// rtl/lim_integrator.sv - pipelined integral accumulator with power-of-two clamp (option: LIM_INTEGRATOR_SATCNT_EN adds sat_cnt)
module lim_integrator #(
  parameter int IW  = 14,
  parameter int KW  = 14,
  parameter int ACC = 32,
  parameter int LW  = 5,
  parameter int SH  = 13,
  parameter int RES = 14
) (
  input  logic          clk,
  input  logic          rst,
  lim_integrator_if.slave bus,
  input  logic [LW-1:0] lim,
  input  logic          hold,
  input  logic          clr,
  input  logic          sat_clr,
  output logic          sat_pos,
  output logic          sat_neg,
`ifdef LIM_INTEGRATOR_SATCNT_EN
  output logic          sat_now,
  output logic [15:0]   sat_cnt
`else
  output logic          sat_now
`endif
);

  localparam int PW = IW + KW;

  logic signed [PW-1:0]  prod;
  logic                  v1;
  logic signed [ACC-1:0] acc;

  logic [LW-1:0]         lim_eff;
  logic signed [ACC:0]   sum;
  logic signed [ACC:0]   hi;
  logic signed [ACC:0]   lo;
  logic                  over_hi;
  logic                  under_lo;
  logic                  update;
  logic signed [ACC-1:0] acc_next;

  // Stage 1: register the full-width product and its qualifier
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod <= '0;
      v1   <= 1'b0;
    end else begin
      prod <= bus.err * bus.ki;
      v1   <= bus.err_valid & ~hold & ~clr;
    end
  end

  // Stage 2 datapath: one-bit-wider sum cannot wrap, then clamp to [-2^lim, 2^lim-1]
  always_comb begin
    lim_eff  = (int'(lim) >= ACC) ? LW'(ACC - 1) : lim;
    hi       = ({{ACC{1'b0}}, 1'b1} << lim_eff) - {{ACC{1'b0}}, 1'b1};
    lo       = ~hi;
    sum      = $signed({acc[ACC-1], acc}) + $signed({{(ACC + 1 - PW){prod[PW-1]}}, prod});
    over_hi  = sum > hi;
    under_lo = sum < lo;
    acc_next = over_hi ? hi[ACC-1:0] : (under_lo ? lo[ACC-1:0] : sum[ACC-1:0]);
    // A sample sitting in stage 1 is dropped if hold rises while it is there
    update   = v1 & ~hold & ~clr;
  end

  // Stage 2 registers: accumulator, scaled output and per-update clamp status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc           <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      sat_now       <= 1'b0;
    end else if (clr) begin
      acc           <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      sat_now       <= 1'b0;
    end else if (update) begin
      acc           <= acc_next;
      bus.out       <= acc_next[SH+RES-1:SH];
      bus.out_valid <= 1'b1;
      sat_now       <= over_hi | under_lo;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

  // Sticky clamp flags; a new clamp event beats a simultaneous sat_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_pos <= 1'b0;
      sat_neg <= 1'b0;
    end else begin
      if (update && over_hi) sat_pos <= 1'b1;
      else if (sat_clr)      sat_pos <= 1'b0;
      if (update && under_lo) sat_neg <= 1'b1;
      else if (sat_clr)       sat_neg <= 1'b0;
    end
  end

`ifdef LIM_INTEGRATOR_SATCNT_EN
  // Saturating count of clamped updates; restarts at 1 if cleared on a clamp
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (clr) begin
      sat_cnt <= '0;
    end else if (update && (over_hi || under_lo)) begin
      if (sat_clr)                 sat_cnt <= 16'd1;
      else if (sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end
  end
`endif

endmodule

// File: doc/lim_integrator.md
Name: lim_integrator

Overview:
Pipelined PID integral-path accumulator: err*ki summed into a wide accumulator with clamp-type anti-windup.
Clamp window is set at run time by a power-of-two limit code; acc limited to [-2^lim, 2^lim-1].
The scaled accumulator drives the downstream combinational saturation stage, which has the same limit encoding, so the integrator never winds up past what that stage passes.
Includes valid handshake, hold/clear control and saturation flags for the register bank.

Parameters:
IW, 14, error input width (signed)
KW, 14, gain width (signed)
ACC, 32, accumulator width (signed); must be >= IW+KW+1
LW, 5, limit code width; 2^LW >= ACC
SH, 13, output right-shift (arithmetic) applied to acc
RES, 14, output width; SH+RES <= ACC

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
err  in  IW  signed error sample
err_valid  in  1  err qualifier, one sample per high cycle
ki  in  KW  signed integral gain, sampled with err
lim  in  LW  clamp code, 0..ACC-1; values >= ACC treated as ACC-1
hold  in  1  freeze accumulator (samples discarded)
clr  in  1  synchronous accumulator clear
sat_clr  in  1  clears sticky flags
out  out  RES  signed acc>>>SH, bits [SH+RES-1:SH]
out_valid  out  1  one-cycle pulse per accumulated sample
sat_pos  out  1  sticky: positive clamp occurred
sat_neg  out  1  sticky: negative clamp occurred
sat_now  out  1  clamp active on last update (registered)

Behaviour:
- Reset (rst=0, async): product reg, acc, out, out_valid, sat_pos, sat_neg, sat_now all 0. Release takes effect on the next rising edge.
- Stage 1 (cycle N+1 after err_valid at N): prod = err*ki, full IW+KW width. v1 <= err_valid & ~hold & ~clr.
- Stage 2 (cycle N+2): sum = sign-extended acc + sign-extended prod, ACC+1 bits, so no wrap. hi = 2^lim-1, lo = -2^lim. Clamp sum to [lo,hi] -> acc; sat_now <= (sum>hi)|(sum<lo). Sum exactly on a bound is not saturation.
- out registered from acc, same edge; out_valid=1 for that one cycle. Latency err_valid->out_valid = 2 cycles. Fully pipelined, accepts a sample every cycle.
- lim changed downward mid-run: next update clamps the old acc value too, since the clamp acts on the sum. No update occurs without a valid sample.
- hold=1: no acc update, out_valid stays 0, out keeps its value. A sample already in stage 1 when hold rises is dropped.
- clr=1: acc<=0, out<=0, v1<=0, sat_now<=0 next edge; in-flight sample discarded. clr has priority over hold and valid. Sticky flags unaffected.
- Sticky: sat_pos set when stage-2 sum>hi, sat_neg when sum<lo. Held until sat_clr=1 or reset. sat_clr and a new clamp event in the same cycle: set wins.
- ki=0 or err=0: acc unchanged but out_valid still pulses.
- All arithmetic signed two's complement. No rounding; truncation toward -inf via arithmetic shift.

Optional Feature:
Macro LIM_INTEGRATOR_SATCNT_EN.
Defined:
- adds output sat_cnt [15:0]: counts stage-2 updates with sat_now.
- saturates at 16'hFFFF, no wrap.
- cleared by sat_clr, clr or reset; if sat_clr and a saturating update coincide, sat_cnt becomes 1.
Undefined: port absent, no counter logic.

Test Plan:
- Reset: drive rst=0 mid-accumulation with acc=5000 -> all outputs 0 immediately (async, before next edge); after release, first valid sample err=1,ki=1 -> acc=1.
- Accumulate: err=1000, ki=8, lim=31, three consecutive valids -> out_valid pulses at cycles 2,3,4; acc 8000,16000,24000; out=2 on last (24000>>>13).
- Positive clamp: lim=10, err=100, ki=1, 11 samples -> acc 1000 after 10th, 1023 after 11th; sat_now=1 and sat_pos=1 only on 11th; sat_neg=0.
- Negative clamp + sticky clear: lim=4, err=-10, ki=1, 2 samples -> acc -10 then -16, sat_neg=1. sat_clr pulse -> sat_neg=0. Coincident sat_clr and clamp -> sat_neg stays 1.
- Hold/clear: acc=500, assert hold 3 cycles with valid samples -> acc=500, no out_valid. Assert clr with a sample in stage 1 -> acc=0, that sample lost, sticky flags kept.
- Limit shrink: acc=1000, lim changed 31->8, sample err=0, ki=0 -> acc=255, sat_pos=1; with LIM_INTEGRATOR_SATCNT_EN, sat_cnt increments by 1.
